oam_dma_controller: RTL and testbench

- Bus initiator for the DMG OAM DMA engine: a CPU write to the DMA register starts a 160-byte copy from (src_hi<<8) into OAM at FE00-FE9F.
- Drives the same read/write bus protocol that peripherals respond to: addr, read_en, write_en, wdata out; combinational rdata in, valid in the cycle read_en is high.
- Sits beside the CPU. The top-level arbiter gives the bus to this block whenever dma_active is high.

---
 rtl/oam_dma_controller.sv | 98 +++++++++
 tb/tb_oam_dma_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA bus initiator: copies LEN bytes from (src_reg<<8) into OAM.
module oam_dma_controller #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] DEST_BASE = 16'hFE00,
    parameter int          LEN       = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_read_en,
    output logic        dma_write_en,
    output logic [7:0]  dma_wdata,
    input  logic [7:0]  dma_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    localparam logic [8:0] LEN_W = 9'(LEN);

    state_t      state;
    state_t      state_next;
    logic [7:0]  index;
    logic [7:0]  src_reg;
    logic [7:0]  latch;
    logic [7:0]  eff_hi;
    logic [8:0]  index_inc;
    logic        reg_wr;

    assign reg_wr    = cpu_we && (cpu_addr == REG_ADDR);
    assign cpu_rdata = (cpu_re && (cpu_addr == REG_ADDR)) ? src_reg : 8'hFF;
    assign index_inc = {1'b0, index} + 9'd1;

    // E0-FF alias the echo-RAM mirror of C0-DF
    assign eff_hi = (src_reg >= 8'hE0) ? (src_reg & 8'hDF) : src_reg;

    always_comb begin
        state_next   = state;
        dma_addr     = 16'h0000;
        dma_read_en  = 1'b0;
        dma_write_en = 1'b0;
        dma_wdata    = 8'h00;
        dma_active   = 1'b0;
        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            START: begin
                dma_active = 1'b1;
                state_next = READ;
            end
            READ: begin
                dma_active  = 1'b1;
                dma_addr    = {eff_hi, index};
                dma_read_en = 1'b1;
                state_next  = WRITE;
            end
            WRITE: begin
                dma_active   = 1'b1;
                dma_addr     = DEST_BASE + {8'h00, index};
                dma_write_en = 1'b1;
                dma_wdata    = latch;
                state_next   = (index_inc < LEN_W) ? READ : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A register write overrides whatever the sequencer would do this edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            index   <= 8'h00;
            src_reg <= 8'hFF;
            latch   <= 8'h00;
        end else if (reg_wr) begin
            src_reg <= cpu_wdata;
            index   <= 8'h00;
            state   <= START;
        end else begin
            state <= state_next;
            if (state == READ) begin
                latch <= dma_rdata;
            end
            if (state == WRITE) begin
                index <= index_inc[7:0];
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - scoreboard bench for oam_dma_controller with a random-memory responder.
module tb_oam_dma_controller;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_rdata;
    logic [15:0] dma_addr;
    logic        dma_read_en;
    logic        dma_write_en;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        dma_active;

    oam_dma_controller dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_rdata    (cpu_rdata),
        .dma_addr     (dma_addr),
        .dma_read_en  (dma_read_en),
        .dma_write_en (dma_write_en),
        .dma_wdata    (dma_wdata),
        .dma_rdata    (dma_rdata),
        .dma_active   (dma_active)
    );

    typedef struct {
        int          cyc;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic [7:0] mem [0:65535];
    txn_t       q[$];
    int         cyc = 0;
    int         act_start = 1;
    int         act_end = 0;
    logic [7:0] src_m = 8'hFF;
    int         run_len = 0;
    int         last_run = 0;
    int         errors = 0;
    int         checks = 0;

    assign dma_rdata = mem[dma_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a transfer started at edge p is START in cycle p, then byte i
    // is read at p+1+2i and written at p+2+2i; the bus is owned for 1+2*160 cycles.
    task automatic push_transfer(input int p, input logic [7:0] s);
        logic [7:0] hi;
        txn_t t;
        hi = (s >= 8'hE0) ? (s - 8'h20) : s;
        for (int i = 0; i < 160; i++) begin
            t.cyc = p + 1 + 2 * i;
            t.wr = 1'b0;
            t.addr = {hi, 8'(i)};
            t.data = 8'h00;
            q.push_back(t);
            t.cyc = p + 2 + 2 * i;
            t.wr = 1'b1;
            t.addr = 16'hFE00 + 16'(i);
            t.data = mem[{hi, 8'(i)}];
            q.push_back(t);
        end
        act_start = p;
        act_end = p + 320;
    endtask

    always @(negedge clk) begin
        txn_t e;
        chk("dma_active", {31'b0, dma_active}, {31'b0, (cyc >= act_start && cyc <= act_end)});
        if (dma_active) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len = 0;
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_txn_cycle", 32'(cyc), 32'(e.cyc));
        end
        if (dma_read_en || dma_write_en) begin
            chk("strobe_exclusive", {30'b0, dma_read_en, dma_write_en} & 32'h3, (dma_write_en ? 32'h1 : 32'h2));
            if (q.size() == 0 || q[0].cyc != cyc) begin
                chk("unexpected_strobe_addr", {16'h0, dma_addr}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("txn_kind_is_write", {31'b0, dma_write_en}, {31'b0, e.wr});
                chk("txn_addr", {16'h0, dma_addr}, {16'h0, e.addr});
                if (e.wr) chk("txn_wdata", {24'h0, dma_wdata}, {24'h0, e.data});
            end
        end else begin
            chk("idle_addr", {16'h0, dma_addr}, 32'h0);
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_we = 1'b1;
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        if (a == 16'hFF46) begin
            q.delete();
            src_m = d;
            push_transfer(cyc, d);
        end
    endtask

    task automatic cpu_read(input logic [15:0] a, input string nm);
        @(posedge clk);
        #1;
        cpu_addr = a;
        cpu_re = 1'b1;
        #1;
        chk(nm, {24'h0, cpu_rdata}, {24'h0, (a == 16'hFF46) ? src_m : 8'hFF});
        cpu_re = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((dma_active || q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("wait_idle_timeout", 32'(n), 32'(0));
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s;
        int op;
        reset = 1'b0;
        cpu_addr = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) mem[16'hC000 + a] = 8'(a) ^ 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        cpu_addr = 16'hFF46;
        cpu_re = 1'b1;
        #1;
        chk("reset_cpu_rdata", {24'h0, cpu_rdata}, 32'hFF);
        chk("reset_read_en", {31'b0, dma_read_en}, 32'h0);
        chk("reset_write_en", {31'b0, dma_write_en}, 32'h0);
        chk("reset_active", {31'b0, dma_active}, 32'h0);
        chk("reset_addr", {16'h0, dma_addr}, 32'h0);
        cpu_re = 1'b0;
        cpu_addr = 16'h0000;
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);

        cpu_write(16'hFF46, 8'hC0);
        wait_idle();
        chk("basic_active_len", 32'(last_run), 32'd321);

        cpu_write(16'hFF46, 8'hE3);
        wait_idle();
        chk("echo_active_len", 32'(last_run), 32'd321);

        cpu_write(16'hFF46, 8'h80);
        repeat (99) @(posedge clk);
        cpu_write(16'hFF46, 8'h90);
        wait_idle();
        chk("restart_active_len", 32'(last_run), 32'd422);

        cpu_write(16'hFF46, 8'hC0);
        repeat (21) @(posedge clk);
        #3;
        reset = 1'b0;
        q.delete();
        act_start = 1;
        act_end = 0;
        src_m = 8'hFF;
        cpu_addr = 16'hFF46;
        cpu_re = 1'b1;
        #1;
        chk("midreset_read_en", {31'b0, dma_read_en}, 32'h0);
        chk("midreset_write_en", {31'b0, dma_write_en}, 32'h0);
        chk("midreset_active", {31'b0, dma_active}, 32'h0);
        chk("midreset_cpu_rdata", {24'h0, cpu_rdata}, 32'hFF);
        cpu_re = 1'b0;
        cpu_addr = 16'h0000;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (30) @(posedge clk);
        wait_idle();
        chk("midreset_active_len", 32'(last_run), 32'd21);

        cpu_write(16'hFF46, 8'h12);
        repeat (10) @(posedge clk);
        cpu_write(16'hFF45, 8'h34);
        cpu_write(16'hFF47, 8'h56);
        cpu_read(16'hFF46, "iso_read_ff46");
        cpu_read(16'hFF45, "iso_read_ff45");
        wait_idle();
        chk("iso_active_len", 32'(last_run), 32'd321);

        for (int t = 0; t < 6; t++) begin
            s = 8'($urandom);
            cpu_write(16'hFF46, s);
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(5, 60)) @(posedge clk);
                op = $urandom_range(0, 3);
                case (op)
                    0: cpu_write(16'hFF45, 8'($urandom));
                    1: cpu_write(16'hFF47, 8'($urandom));
                    2: cpu_read(16'hFF46, "rand_read_ff46");
                    default: cpu_read(16'hFF45, "rand_read_ff45");
                endcase
            end
            if ($urandom_range(0, 2) == 0) cpu_write(16'hFF46, 8'($urandom));
            wait_idle();
            cpu_read(16'hFF46, "rand_final_ff46");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
